// File: rtl/cve2_obi_resp_pkg.sv
// Shared types and limits for the instruction-side OBI responder.
// The response entry travels down the delay line, one stage per cycle.
package cve2_obi_resp_pkg;

    localparam int MAX_NUM_REQS     = 4;
    localparam int MAX_RESP_LATENCY = 4;
    localparam int MAX_WAIT_CYCLES  = 7;
    localparam int WAIT_CNT_W       = 3;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic        src_sram;
        logic [31:0] rdata;
    } resp_entry_t;

    localparam int RESP_ENTRY_W = $bits(resp_entry_t);

endpackage

// File: rtl/cve2_obi_resp_pipe.sv
// Fixed-latency response delay line: an entry enters on grant and leaves
// RESP_LATENCY cycles later; SRAM data is captured on the first shift.
module cve2_obi_resp_pipe
    import cve2_obi_resp_pkg::*;
#(
    parameter int RESP_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [RESP_ENTRY_W-1:0] entry_i,
    input  logic [31:0]             mem_rdata_i,
    output logic [RESP_ENTRY_W-1:0] entry_o
);

    resp_entry_t r_stage [RESP_LATENCY];
    resp_entry_t w_src   [RESP_LATENCY];
    resp_entry_t w_head;

    // SRAM data is only valid the cycle after the strobe, i.e. while the
    // entry sits in stage 0, so it is merged in there and carried onward.
    always_comb begin
        w_head = r_stage[0];
        if (r_stage[0].src_sram) begin
            w_head.rdata = mem_rdata_i;
        end
    end

    genvar gi;
    for (gi = 0; gi < RESP_LATENCY; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign w_src[gi] = resp_entry_t'(entry_i);
        end else if (gi == 1) begin : g_capture
            assign w_src[gi] = w_head;
        end else begin : g_shift
            assign w_src[gi] = r_stage[gi-1];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < RESP_LATENCY; i++) begin
            if (rst_i) begin
                r_stage[i] <= '0;
            end else begin
                r_stage[i] <= w_src[i];
            end
        end
    end

    if (RESP_LATENCY == 1) begin : g_out_direct
        assign entry_o = w_head;
    end else begin : g_out_reg
        assign entry_o = r_stage[RESP_LATENCY-1];
    end

endmodule

// File: rtl/cve2_instr_obi_responder.sv
// OBI instruction-fetch responder in front of a single-port SRAM with a
// one-cycle read; grants are throttled by a wait counter and a slot limit.
module cve2_instr_obi_responder
    import cve2_obi_resp_pkg::*;
#(
    parameter int          NUM_REQS     = 2,
    parameter int          RESP_LATENCY = 1,
    parameter int          WAIT_CYCLES  = 0,
    parameter logic [31:0] MEM_BASE     = 32'h0000_0000,
    parameter int          MEM_WORDS    = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         instr_req_i,
    output logic                         instr_gnt_o,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    output logic                         mem_req_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    input  logic [31:0]                  mem_rdata_i
);

    localparam int          AW      = $clog2(MEM_WORDS);
    localparam logic [32:0] BASE_X  = {1'b0, MEM_BASE};
    localparam logic [32:0] LIMIT_X = BASE_X + 33'(MEM_WORDS) * 33'd4;

    if (NUM_REQS < 1 || NUM_REQS > MAX_NUM_REQS ||
        RESP_LATENCY < 1 || RESP_LATENCY > MAX_RESP_LATENCY ||
        WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT_CYCLES) begin : g_bad_params
        $error("cve2_instr_obi_responder: parameter out of range");
    end

    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [2:0]              r_outstanding;
    logic                    w_gnt;
    logic                    w_retire;
    logic                    w_slot_free;
    logic                    w_in_range;
    logic [31:0]             w_offset;
    resp_entry_t             w_entry_in;
    resp_entry_t             w_entry_out;
    logic [RESP_ENTRY_W-1:0] w_entry_out_bits;
    logic                    w_unused_bits;

    assign w_offset   = instr_addr_i - MEM_BASE;
    assign w_in_range = ({1'b0, instr_addr_i} >= BASE_X) && ({1'b0, instr_addr_i} < LIMIT_X);

    // A response leaving this cycle frees its slot for a same-cycle grant.
    assign w_retire    = w_entry_out.valid && !rst_i;
    assign w_slot_free = ({1'b0, r_outstanding} - {3'b000, w_retire}) < 4'(NUM_REQS);
    assign w_gnt       = !rst_i && instr_req_i && (r_wait_cnt == WAIT_CNT_W'(WAIT_CYCLES)) && w_slot_free;

    always_comb begin
        w_entry_in          = '0;
        w_entry_in.valid    = w_gnt;
        w_entry_in.err      = w_gnt && !w_in_range;
        w_entry_in.src_sram = w_gnt && w_in_range;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !instr_req_i || w_gnt) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt < WAIT_CNT_W'(WAIT_CYCLES)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= r_outstanding + {2'b00, w_gnt} - {2'b00, w_retire};
        end
    end

    cve2_obi_resp_pipe #(
        .RESP_LATENCY (RESP_LATENCY)
    ) u_resp_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .entry_i     (w_entry_in),
        .mem_rdata_i (mem_rdata_i),
        .entry_o     (w_entry_out_bits)
    );

    assign w_entry_out    = resp_entry_t'(w_entry_out_bits);
    assign instr_gnt_o    = w_gnt;
    assign instr_rvalid_o = w_retire;
    assign instr_err_o    = w_retire && w_entry_out.err;
    assign instr_rdata_o  = w_retire ? w_entry_out.rdata : 32'h0;
    assign mem_req_o      = w_gnt && w_in_range;
    assign mem_addr_o     = w_offset[AW+1:2];

    assign w_unused_bits = ^{w_offset[31:AW+2], w_offset[1:0], w_entry_out.src_sram};

    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (instr_req_i && !instr_gnt_o) |=> $stable(instr_addr_i));
    a_outstanding_max: assert property (@(posedge clk_i)
        r_outstanding <= 3'(NUM_REQS));
    a_no_rvalid_idle: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_outstanding == 3'd0) |-> !instr_rvalid_o);

endmodule

// File: tb/tb_cve2_instr_obi_responder.sv
// Four responder configurations run side by side, each against a
// transaction-level model: a queue of responses tagged with their due cycle.
module tb_cve2_instr_obi_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    function automatic logic [31:0] mem_word(input int lane_i, input int idx);
        if (idx == 0) return 32'h0041_0113;
        return (32'(idx) * 32'h9E37_79B1) ^ 32'(lane_i << 24) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input int lane_i, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL lane %0d %s actual %h required %h at t=%0t", lane_i, nm, act, exp_v, $time);
        end
    endtask

    localparam int N_LANES = 4;

    genvar gi;
    for (gi = 0; gi < N_LANES; gi++) begin : lane
        localparam int          NR    = (gi == 3) ? 4 : (gi == 2) ? 3 : 2;
        localparam int          LAT   = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 2 : 4;
        localparam int          WC    = (gi == 2) ? 2 : (gi == 3) ? 1 : 0;
        localparam logic [31:0] BASE  = (gi == 2) ? 32'h0000_2000 : (gi == 3) ? 32'hFFFF_F000 : 32'h0;
        localparam int          WORDS = (gi == 2) ? 256 : 1024;
        localparam int          AW    = $clog2(WORDS);
        localparam longint      LIMIT = longint'(BASE) + 4 * longint'(WORDS);

        logic          rst = 1'b1;
        logic          req = 1'b0;
        logic [31:0]   addr = 32'h0;
        logic          gnt, rvalid, err, mreq;
        logic [31:0]   rdata;
        logic [31:0]   sram_q = 32'h0;
        logic [AW-1:0] maddr;

        cve2_instr_obi_responder #(
            .NUM_REQS     (NR),
            .RESP_LATENCY (LAT),
            .WAIT_CYCLES  (WC),
            .MEM_BASE     (BASE),
            .MEM_WORDS    (WORDS)
        ) u_dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .instr_req_i    (req),
            .instr_gnt_o    (gnt),
            .instr_addr_i   (addr),
            .instr_rvalid_o (rvalid),
            .instr_rdata_o  (rdata),
            .instr_err_o    (err),
            .mem_req_o      (mreq),
            .mem_addr_o     (maddr),
            .mem_rdata_i    (sram_q)
        );

        // SRAM: data only meaningful the cycle after a strobe, junk otherwise.
        always @(posedge clk) begin
            sram_q <= mreq ? mem_word(gi, int'(maddr)) : ($urandom() ^ 32'hBAD0_0000);
        end

        int          cyc = 0;
        int          waited = 0;
        int          t0 = 0;
        bit          seen_gnt = 1'b0;
        bit          log_on = 1'b0;
        bit          done = 1'b0;
        exp_t        q[$];
        int          ng = 0;
        int          nr = 0;
        int          g_cyc [64];
        logic        g_mreq [64];
        logic [31:0] g_maddr [64];
        int          r_cyc [64];
        logic [31:0] r_data [64];
        logic        r_err [64];

        initial begin
            bit          retire, e_gnt, inr;
            longint      a;
            logic [31:0] e_data;
            logic        e_err;
            exp_t        e;
            forever begin
                @(negedge clk);
                a      = longint'(addr);
                inr    = (a >= longint'(BASE)) && (a < LIMIT);
                retire = !rst && (q.size() > 0) && (q[0].due == cyc);
                e_data = 32'h0;
                e_err  = 1'b0;
                if (retire) begin
                    e_data = q[0].data;
                    e_err  = q[0].err;
                end
                e_gnt = !rst && req && (waited >= WC) && ((q.size() - int'(retire)) < NR);
                chk(gi, "gnt", 32'(gnt), 32'(e_gnt));
                chk(gi, "mem_req", 32'(mreq), 32'(e_gnt && inr));
                if (e_gnt && inr) chk(gi, "mem_addr", 32'(maddr), 32'((a - longint'(BASE)) / 4));
                chk(gi, "rvalid", 32'(rvalid), 32'(retire));
                chk(gi, "rdata", rdata, e_data);
                chk(gi, "err", 32'(err), 32'(e_err));
                if (rvalid === 1'b1)
                    $display("lane %0d cyc %0d response rdata %h err %b", gi, cyc, rdata, err);
                if (log_on && gnt === 1'b1 && ng < 64) begin
                    g_cyc[ng] = cyc - t0; g_mreq[ng] = mreq; g_maddr[ng] = 32'(maddr); ng++;
                end
                if (log_on && rvalid === 1'b1 && nr < 64) begin
                    r_cyc[nr] = cyc - t0; r_data[nr] = rdata; r_err[nr] = err; nr++;
                end
                seen_gnt = (gnt === 1'b1);
                if (rst) begin
                    q.delete();
                    waited = 0;
                end else begin
                    if (retire) void'(q.pop_front());
                    if (e_gnt) begin
                        e.due  = cyc + LAT;
                        e.data = inr ? mem_word(gi, int'((a - longint'(BASE)) / 4)) : 32'h0;
                        e.err  = !inr;
                        q.push_back(e);
                    end
                    waited = (!req || e_gnt) ? 0 : waited + 1;
                end
                cyc++;
            end
        end

        task automatic issue(input logic [31:0] a);
            int k;
            req  = 1'b1;
            addr = a;
            k    = 0;
            do begin
                @(posedge clk); #1;
                k++;
            end while (!seen_gnt && k < 64);
            chk(gi, "gnt_within_bound", 32'(seen_gnt), 32'd1);
        endtask

        initial begin
            int          sel;
            logic [31:0] a;
            rst  = 1'b1;
            req  = 1'b1;
            addr = BASE;
            repeat (3) @(posedge clk);
            #1;
            rst    = 1'b0;
            t0     = cyc;
            log_on = 1'b1;
            issue(BASE);
            issue(BASE + 32'd4);
            issue(BASE + 32'd8);
            issue(BASE + 32'(4 * WORDS));
            for (int k = 0; k < 16; k++) issue(BASE + 32'd16 + 32'(4 * k));
            req = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            issue(BASE + 32'd8);
            req = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            log_on = 1'b0;
            for (int n = 0; n < 120; n++) begin
                sel = $urandom_range(0, 9);
                if (sel <= 5)      a = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
                else if (sel == 6) a = BASE + 32'(4 * WORDS - 4) + 32'($urandom_range(0, 3));
                else if (sel == 7) a = BASE + 32'(4 * WORDS);
                else if (sel == 8) a = BASE - 32'd4;
                else               a = $urandom();
                if ($urandom_range(0, 2) == 0) begin
                    req = 1'b0;
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                end
                if ($urandom_range(0, 29) == 0) begin
                    req = 1'b0;
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                end
                issue(a);
            end
            req = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            done = 1'b1;
        end
    end

    initial begin
        int budget;
        budget = 0;
        while (!(lane[0].done && lane[1].done && lane[2].done && lane[3].done) && budget < 30000) begin
            @(negedge clk);
            budget++;
        end
        chk(-1, "lanes_done", 32'(lane[0].done && lane[1].done && lane[2].done && lane[3].done), 32'd1);

        // defaults: single fetch, boundary error, 16+ back-to-back words, reset
        chk(0, "first_gnt_cyc",   32'(lane[0].g_cyc[0]), 32'd0);
        chk(0, "first_mem_req",   32'(lane[0].g_mreq[0]), 32'd1);
        chk(0, "first_mem_addr",  lane[0].g_maddr[0], 32'd0);
        chk(0, "first_rsp_cyc",   32'(lane[0].r_cyc[0]), 32'd1);
        chk(0, "first_rsp_data",  lane[0].r_data[0], 32'h0041_0113);
        chk(0, "first_rsp_err",   32'(lane[0].r_err[0]), 32'd0);
        chk(0, "oor_mem_req",     32'(lane[0].g_mreq[3]), 32'd0);
        chk(0, "oor_rsp_err",     32'(lane[0].r_err[3]), 32'd1);
        chk(0, "oor_rsp_data",    lane[0].r_data[3], 32'h0);
        chk(0, "gnt20_cyc",       32'(lane[0].g_cyc[19]), 32'd19);
        chk(0, "rsp20_cyc",       32'(lane[0].r_cyc[19]), 32'd20);
        chk(0, "post_rst_gnt",    32'(lane[0].g_cyc[20]), 32'd22);
        chk(0, "post_rst_rsp",    32'(lane[0].r_cyc[20]), 32'd23);
        chk(0, "rsp_count",       32'(lane[0].nr), 32'd21);
        // NUM_REQS=2, RESP_LATENCY=3
        chk(1, "gnt0_cyc",        32'(lane[1].g_cyc[0]), 32'd0);
        chk(1, "gnt1_cyc",        32'(lane[1].g_cyc[1]), 32'd1);
        chk(1, "gnt2_cyc",        32'(lane[1].g_cyc[2]), 32'd3);
        chk(1, "rsp0_cyc",        32'(lane[1].r_cyc[0]), 32'd3);
        chk(1, "rsp1_cyc",        32'(lane[1].r_cyc[1]), 32'd4);
        chk(1, "rsp2_cyc",        32'(lane[1].r_cyc[2]), 32'd6);
        chk(1, "rsp_count_rst",   32'(lane[1].nr), 32'd19);
        chk(1, "post_rst_gnt",    32'(lane[1].g_cyc[20]), 32'd31);
        chk(1, "post_rst_rsp",    32'(lane[1].r_cyc[18]), 32'd34);
        // WAIT_CYCLES=2, base 0x2000
        chk(2, "wait_gnt0_cyc",   32'(lane[2].g_cyc[0]), 32'd2);
        chk(2, "wait_gnt1_cyc",   32'(lane[2].g_cyc[1]), 32'd5);
        chk(2, "wait_rsp0_cyc",   32'(lane[2].r_cyc[0]), 32'd4);
        chk(2, "oor_mem_req",     32'(lane[2].g_mreq[3]), 32'd0);
        chk(2, "oor_rsp_err",     32'(lane[2].r_err[3]), 32'd1);
        // base at top of address space: base+size wraps to 0 and is out of range
        chk(3, "gnt0_cyc",        32'(lane[3].g_cyc[0]), 32'd1);
        chk(3, "rsp0_cyc",        32'(lane[3].r_cyc[0]), 32'd5);
        chk(3, "rsp0_data",       lane[3].r_data[0], 32'h0041_0113);
        chk(3, "wrap_mem_req",    32'(lane[3].g_mreq[3]), 32'd0);
        chk(3, "wrap_rsp_err",    32'(lane[3].r_err[3]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
